// File: rtl/axi4_lite_slave_read_responder_pkg.sv
// Shared types for the AXI4-Lite slave read responder.
//   AXI_ADDRESS_WIDTH / AXI_DATA_WIDTH : default bus widths
//   resp_e  : AXI read response codes
//   state_e : read-channel FSM states
//   LAT_W   : width of the wait-state counter (READ_LATENCY 0..7)
package axi4_lite_slave_read_responder_pkg;

    localparam int unsigned AXI_ADDRESS_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH    = 32;
    localparam int unsigned LAT_W             = 3;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/axi4_lite_sync_fifo.sv
// Synchronous FIFO used as the outstanding AR queue.
//   clk, rst_n   : clock, async active-low reset
//   push, din    : write side (ignored when full)
//   pop          : read side (ignored when empty)
//   dout         : head entry, valid when !empty
//   full, empty  : registered occupancy flags
//   full_nxt_c   : combinational value full takes after this edge
module axi4_lite_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             full_nxt_c,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Pointer/occupancy update; flags are registered from the next count.
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout       = mem_q[rd_ptr_q];
    assign full       = full_q;
    assign empty      = empty_q;
    assign full_nxt_c = full_d;

endmodule

// File: rtl/axi4_lite_slave_read_responder.sv
// AXI4-Lite slave read-channel responder with outstanding-request queue,
// programmable wait states, range/protection SLVERR and a preload port.
//   aclk, aresetn              : clock, async active-low reset
//   araddr/arprot/arvalid      : AR request in; arready registered out
//   rdata/rresp/rvalid, rready : R beat out (registered), ready in
//   mem_we/mem_waddr/mem_wdata : backing-store preload write
module axi4_lite_slave_read_responder
    import axi4_lite_slave_read_responder_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = AXI_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = AXI_DATA_WIDTH,
    parameter int unsigned NUM_WORDS     = 16,
    parameter int unsigned OUTSTANDING   = 2,
    parameter int unsigned READ_LATENCY  = 0,
    parameter int unsigned PRIV_ONLY     = 0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [ADDRESS_WIDTH-1:0]     araddr,
    input  logic [2:0]                   arprot,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    input  logic                         mem_we,
    input  logic [$clog2(NUM_WORDS)-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]        mem_wdata
);

    localparam int unsigned IDX_W    = $clog2(NUM_WORDS);
    localparam int unsigned OFF_W    = $clog2(DATA_WIDTH / 8);
    localparam int unsigned ENTRY_W  = IDX_W + 1;
    localparam int unsigned LAT_INIT = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

    logic [ADDRESS_WIDTH-1:0] word_addr;
    logic                     ar_err;
    logic [ENTRY_W-1:0]       ar_entry;
    logic                     push;
    logic                     pop;
    logic                     fifo_empty;
    logic                     fifo_full_unused;
    logic                     fifo_full_nxt;
    logic [ENTRY_W-1:0]       fifo_dout;
    logic                     unused_prot;

    state_e                   state_q, state_d;
    logic [LAT_W-1:0]         cnt_q, cnt_d;
    logic [ENTRY_W-1:0]       entry_q, entry_d;
    logic                     arready_q, arready_d;
    logic                     rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    resp_e                    rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]    store_q [NUM_WORDS];

    logic                     launch;
    logic                     load;
    logic [ENTRY_W-1:0]       load_entry;

    // AR decode: queue entry is {word index, error flag}.
    assign word_addr   = araddr >> OFF_W;
    assign ar_err      = (word_addr >= ADDRESS_WIDTH'(NUM_WORDS))
                      || ((PRIV_ONLY != 0) && !arprot[0]);
    assign ar_entry    = {word_addr[IDX_W-1:0], ar_err};
    assign push        = arvalid && arready_q;
    assign unused_prot = ^arprot[2:1];

    axi4_lite_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OUTSTANDING)
    ) u_ar_fifo (
        .clk        (aclk),
        .rst_n      (aresetn),
        .push       (push),
        .din        (ar_entry),
        .pop        (pop),
        .full       (fifo_full_unused),
        .empty      (fifo_empty),
        .full_nxt_c (fifo_full_nxt),
        .dout       (fifo_dout)
    );

    // Next-state / beat generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        entry_d    = entry_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        pop        = 1'b0;
        launch     = 1'b0;
        load       = 1'b0;
        load_entry = entry_q;
        arready_d  = !fifo_full_nxt;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    launch = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    load    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rready) begin
                    if (!fifo_empty) begin
                        launch = 1'b1;
                    end else begin
                        rvalid_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pop the head; with zero latency the beat is loaded on this same edge.
        if (launch) begin
            pop = 1'b1;
            if (READ_LATENCY == 0) begin
                load       = 1'b1;
                load_entry = fifo_dout;
                state_d    = RESP;
            end else begin
                entry_d  = fifo_dout;
                cnt_d    = LAT_W'(LAT_INIT);
                rvalid_d = 1'b0;
                state_d  = WAIT;
            end
        end

        if (load) begin
            rvalid_d = 1'b1;
            if (load_entry[0]) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rdata_d = store_q[load_entry[ENTRY_W-1:1]];
                rresp_d = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            entry_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            entry_q   <= entry_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Backing store; a beat loaded on a write edge sees the old word.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            store_q[mem_waddr] <= mem_wdata;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_read_responder.sv
// Bench: instance A (defaults, zero latency) and instance B (latency 3,
// privileged-only), scoreboard queues filled at AR handshake, drained at R handshake.
module tb_axi4_lite_slave_read_responder;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic aresetn = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_araddr, b_araddr;
    logic [2:0]  a_arprot, b_arprot;
    logic        a_arvalid, b_arvalid, a_arready, b_arready;
    logic [31:0] a_rdata, b_rdata;
    logic [1:0]  a_rresp, b_rresp;
    logic        a_rvalid, b_rvalid, a_rready, b_rready;
    logic        a_mem_we, b_mem_we;
    logic [3:0]  a_mem_waddr, b_mem_waddr;
    logic [31:0] a_mem_wdata, b_mem_wdata;

    axi4_lite_slave_read_responder u_a (
        .aclk(clk), .aresetn(aresetn),
        .araddr(a_araddr), .arprot(a_arprot), .arvalid(a_arvalid), .arready(a_arready),
        .rdata(a_rdata), .rresp(a_rresp), .rvalid(a_rvalid), .rready(a_rready),
        .mem_we(a_mem_we), .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata)
    );

    axi4_lite_slave_read_responder #(
        .READ_LATENCY (3),
        .PRIV_ONLY    (1)
    ) u_b (
        .aclk(clk), .aresetn(aresetn),
        .araddr(b_araddr), .arprot(b_arprot), .arvalid(b_arvalid), .arready(b_arready),
        .rdata(b_rdata), .rresp(b_rresp), .rvalid(b_rvalid), .rready(b_rready),
        .mem_we(b_mem_we), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [33:0] a_exp[$], b_exp[$];
    int a_times[$], b_times[$];
    int a_total = 0, b_total = 0, a_beats = 0, b_beats = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard drain at R handshake.
    always @(negedge clk) begin
        logic [33:0] got;
        if (a_rvalid && a_rready) begin
            a_beats++;
            a_times.push_back(cyc);
            check("a_beat_expected", 64'(a_exp.size() != 0), 64'd1);
            if (a_exp.size() != 0) begin
                got = a_exp.pop_front();
                check("a_rdata", 64'(a_rdata), 64'(got[31:0]));
                check("a_rresp", 64'(a_rresp), 64'(got[33:32]));
            end
        end
        if (b_rvalid && b_rready) begin
            b_beats++;
            b_times.push_back(cyc);
            check("b_beat_expected", 64'(b_exp.size() != 0), 64'd1);
            if (b_exp.size() != 0) begin
                got = b_exp.pop_front();
                check("b_rdata", 64'(b_rdata), 64'(got[31:0]));
                check("b_rresp", 64'(b_rresp), 64'(got[33:32]));
            end
        end
    end

    task automatic preload(input bit sel, input logic [3:0] idx, input logic [31:0] data);
        if (sel) begin b_mem_we = 1'b1; b_mem_waddr = idx; b_mem_wdata = data; end
        else     begin a_mem_we = 1'b1; a_mem_waddr = idx; a_mem_wdata = data; end
        @(posedge clk); #1;
        a_mem_we = 1'b0;
        b_mem_we = 1'b0;
    endtask

    // Drive one AR; returns at handshake edge + 1, iters = negedges waited.
    task automatic issue(input bit sel, input logic [31:0] addr, input logic [2:0] prot,
                         input logic [33:0] exp, output int iters);
        bit ok = 1'b0;
        iters = -1;
        if (sel) begin b_araddr = addr; b_arprot = prot; b_arvalid = 1'b1; end
        else     begin a_araddr = addr; a_arprot = prot; a_arvalid = 1'b1; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sel ? b_arready : a_arready) begin
                @(posedge clk);
                if (sel) begin b_exp.push_back(exp); b_total++; end
                else     begin a_exp.push_back(exp); a_total++; end
                ok = 1'b1;
                iters = i;
                break;
            end
        end
        #1;
        if (sel) b_arvalid = 1'b0; else a_arvalid = 1'b0;
        if (sel) check("b_ar_accept", 64'(ok), 64'd1);
        else     check("a_ar_accept", 64'(ok), 64'd1);
    endtask

    task automatic drain(input bit sel);
        int n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            n = sel ? (b_exp.size() + int'(b_rvalid)) : (a_exp.size() + int'(a_rvalid));
            if (n == 0) break;
        end
        if (sel) check("b_drain", 64'(n), 64'd0);
        else     check("a_drain", 64'(n), 64'd0);
    endtask

    // Edges from return of issue() until rvalid is seen.
    task automatic latency(input bit sel, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (sel ? b_rvalid : a_rvalid) begin lat = i; break; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int it;
        int lat;
        a_araddr = '0; a_arprot = '0; a_arvalid = 0; a_rready = 0;
        b_araddr = '0; b_arprot = '0; b_arvalid = 0; b_rready = 0;
        a_mem_we = 0; a_mem_waddr = '0; a_mem_wdata = '0;
        b_mem_we = 0; b_mem_waddr = '0; b_mem_wdata = '0;
        #1 aresetn = 1'b0;

        // Preload while in reset; the store is not reset.
        preload(0, 4'd0, 32'h1111_1111);
        preload(0, 4'd1, 32'h2222_2222);
        preload(0, 4'd2, 32'h3333_3333);
        preload(0, 4'd3, 32'hDEAD_BEEF);
        preload(0, 4'd15, 32'hF0F0_F0F0);
        preload(1, 4'd0, 32'hB000_0000);
        preload(1, 4'd1, 32'hB111_1111);
        preload(1, 4'd2, 32'hB222_2222);
        preload(1, 4'd3, 32'hB333_3333);
        preload(1, 4'd5, 32'hCAFE_F00D);

        check("rst_a_arready", 64'(a_arready), 64'd0);
        check("rst_a_rvalid", 64'(a_rvalid), 64'd0);
        check("rst_a_rdata", 64'(a_rdata), 64'd0);
        check("rst_a_rresp", 64'(a_rresp), 64'(OKAY));
        check("rst_b_arready", 64'(b_arready), 64'd0);
        check("rst_b_rvalid", 64'(b_rvalid), 64'd0);

        aresetn = 1'b1;
        check("a_arready_before_edge", 64'(a_arready), 64'd0);
        @(posedge clk); #1;
        check("a_arready_after_edge", 64'(a_arready), 64'd1);
        check("b_arready_after_edge", 64'(b_arready), 64'd1);

        // Single read, zero latency.
        a_rready = 1'b1;
        issue(0, 32'h0000_000C, 3'b000, {OKAY, 32'hDEAD_BEEF}, it);
        latency(0, lat);
        check("a_latency", 64'(lat), 64'd1);
        drain(0);

        // Range errors, byte offset ignored, last valid word.
        issue(0, 32'h0000_0040, 3'b000, {SLVERR, 32'h0}, it);
        issue(0, 32'h0000_0000, 3'b000, {OKAY, 32'h1111_1111}, it);
        issue(0, 32'h0000_000E, 3'b000, {OKAY, 32'hDEAD_BEEF}, it);
        issue(0, 32'hFFFF_FFFC, 3'b000, {SLVERR, 32'h0}, it);
        issue(0, 32'h0000_003C, 3'b000, {OKAY, 32'hF0F0_F0F0}, it);
        drain(0);

        // Preload on the same edge the beat is loaded: old value captured.
        issue(0, 32'h0000_0008, 3'b000, {OKAY, 32'h3333_3333}, it);
        a_mem_we = 1'b1; a_mem_waddr = 4'd2; a_mem_wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        a_mem_we = 1'b0;
        issue(0, 32'h0000_0008, 3'b000, {OKAY, 32'h5A5A_5A5A}, it);
        drain(0);

        // Backpressure: one beat held, two queued, fourth AR stalls.
        a_rready = 1'b0;
        issue(0, 32'h0000_0004, 3'b000, {OKAY, 32'h2222_2222}, it);
        issue(0, 32'h0000_0008, 3'b000, {OKAY, 32'h5A5A_5A5A}, it);
        issue(0, 32'h0000_003C, 3'b000, {OKAY, 32'hF0F0_F0F0}, it);
        a_araddr = 32'h0; a_arvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("a_full_arready", 64'(a_arready), 64'd0);
        check("a_hold_rvalid", 64'(a_rvalid), 64'd1);
        check("a_hold_rdata", 64'(a_rdata), 64'h2222_2222);
        a_rready = 1'b1;
        issue(0, 32'h0000_0000, 3'b000, {OKAY, 32'h1111_1111}, it);
        check("a_slot_release_wait", 64'(it), 64'd1);
        drain(0);

        // Zero-latency streaming: one beat per cycle.
        a_times.delete();
        issue(0, 32'h0000_0000, 3'b000, {OKAY, 32'h1111_1111}, it);
        issue(0, 32'h0000_0004, 3'b000, {OKAY, 32'h2222_2222}, it);
        issue(0, 32'h0000_0008, 3'b000, {OKAY, 32'h5A5A_5A5A}, it);
        issue(0, 32'h0000_000C, 3'b000, {OKAY, 32'hDEAD_BEEF}, it);
        drain(0);
        check("a_stream_beats", 64'(a_times.size()), 64'd4);
        for (int i = 1; i < a_times.size(); i++)
            check("a_stream_spacing", 64'(a_times[i] - a_times[i-1]), 64'd1);

        // Reset mid-flight: held beat and queued requests are discarded.
        a_rready = 1'b0;
        issue(0, 32'h0000_0004, 3'b000, {OKAY, 32'h2222_2222}, it);
        issue(0, 32'h0000_0008, 3'b000, {OKAY, 32'h5A5A_5A5A}, it);
        issue(0, 32'h0000_000C, 3'b000, {OKAY, 32'hDEAD_BEEF}, it);
        @(posedge clk); #1;
        check("a_pre_reset_rvalid", 64'(a_rvalid), 64'd1);
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        check("a_midreset_rvalid", 64'(a_rvalid), 64'd0);
        check("a_midreset_arready", 64'(a_arready), 64'd0);
        a_total -= a_exp.size();
        a_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        a_rready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("a_post_reset_arready", 64'(a_arready), 64'd1);
        check("a_post_reset_rvalid", 64'(a_rvalid), 64'd0);
        check("a_beat_count", 64'(a_beats), 64'(a_total));

        // Instance B: latency 3, privileged-only.
        b_rready = 1'b1;
        issue(1, 32'h0000_0014, 3'b001, {OKAY, 32'hCAFE_F00D}, it);
        latency(1, lat);
        check("b_latency", 64'(lat), 64'd4);
        drain(1);
        issue(1, 32'h0000_0014, 3'b000, {SLVERR, 32'h0}, it);
        issue(1, 32'h0000_0014, 3'b001, {OKAY, 32'hCAFE_F00D}, it);
        issue(1, 32'h0000_0040, 3'b001, {SLVERR, 32'h0}, it);
        drain(1);

        b_times.delete();
        issue(1, 32'h0000_0000, 3'b001, {OKAY, 32'hB000_0000}, it);
        issue(1, 32'h0000_0004, 3'b001, {OKAY, 32'hB111_1111}, it);
        issue(1, 32'h0000_0008, 3'b001, {OKAY, 32'hB222_2222}, it);
        issue(1, 32'h0000_000C, 3'b001, {OKAY, 32'hB333_3333}, it);
        drain(1);
        check("b_stream_beats", 64'(b_times.size()), 64'd4);
        for (int i = 1; i < b_times.size(); i++)
            check("b_stream_spacing", 64'(b_times[i] - b_times[i-1]), 64'd4);
        check("b_beat_count", 64'(b_beats), 64'(b_total));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
